// File: rtl/bk_sched_pkg.sv
// Shared types and constants for the shared Brent-Kung add scheduler.
// Latency: n/a (types, constants and a width helper only).
// Backpressure: n/a.
package bk_sched_pkg;

    // Width of one adder word; operands are processed in slices of this size.
    localparam int BK_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Width of a requester index. Never returns 0, so it is a legal vector width.
    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/BrentKung.sv
// 16-bit Brent-Kung parallel-prefix adder with carry-in.
// Latency: purely combinational.
// Backpressure: none.
// Ports: A, B operands; Cin carry-in; S sum; Cout carry out of bit 15.
module BrentKung (
    input  logic [15:0] A,
    input  logic [15:0] B,
    input  logic        Cin,
    output logic [15:0] S,
    output logic        Cout
);

    logic [15:0] w_p;   // bitwise propagate, kept for the final sum
    logic [15:0] w_g;   // prefix generate; ends up as the carry out of each bit
    logic [15:0] w_pg;  // prefix group propagate

    always_comb begin
        w_p  = A ^ B;
        w_g  = A & B;
        w_pg = w_p;
        // Fold the carry-in into bit 0 so every group ending at bit 0 already includes it.
        w_g[0] = w_g[0] | (w_p[0] & Cin);
        // Up-sweep: build the group terms at bits 1, 3, 7, 15.
        for (int d = 1; d < 16; d = d * 2) begin
            for (int i = 2 * d - 1; i < 16; i = i + 2 * d) begin
                w_g[i]  = w_g[i] | (w_pg[i] & w_g[i - d]);
                w_pg[i] = w_pg[i] & w_pg[i - d];
            end
        end
        // Down-sweep: fill in the remaining bit positions.
        for (int d = 4; d >= 1; d = d / 2) begin
            for (int i = 3 * d - 1; i < 16; i = i + 2 * d) begin
                w_g[i]  = w_g[i] | (w_pg[i] & w_g[i - d]);
                w_pg[i] = w_pg[i] & w_pg[i - d];
            end
        end
        S    = w_p ^ {w_g[14:0], Cin};
        Cout = w_g[15];
    end

endmodule

// File: rtl/rr_arb.sv
// Round-robin arbiter: one-hot grant, search starting just after last_grant.
// Latency: purely combinational.
// Backpressure: none; grant is zero when no request is asserted.
// Ports: req (requests), last_grant (index of previous winner), grant (one-hot).
module rr_arb
    import bk_sched_pkg::*;
#(
    parameter int NREQ = 2
) (
    input  logic [NREQ-1:0]             req,
    input  logic [id_width(NREQ)-1:0]   last_grant,
    output logic [NREQ-1:0]             grant
);

    localparam int IDW = id_width(NREQ);
    localparam logic [IDW:0] ONE = 1;

    logic [IDW:0]    w_shift;
    logic [NREQ-1:0] w_rot;
    logic [NREQ-1:0] w_rot_oh;

    // Rotate so that index last_grant+1 lands at bit 0, pick the lowest set bit,
    // then rotate the one-hot result back. The doubled vectors implement the wrap.
    assign w_shift  = {1'b0, last_grant} + ONE;
    assign w_rot    = NREQ'({req, req} >> w_shift);
    assign w_rot_oh = w_rot & (~w_rot + NREQ'(1));
    assign grant    = NREQ'(({w_rot_oh, w_rot_oh} << w_shift) >> NREQ);

endmodule

// File: rtl/bk_add_scheduler.sv
// Shares one 16-bit Brent-Kung adder among NREQ requesters doing 16*WORDS-bit adds.
// Latency: WORDS+1 cycles from accept to rsp_valid; issue interval WORDS+2 minimum.
// Backpressure: result held in DONE until rsp_ready; req_ready stays low until then.
// Ports: req_valid/req_ready (one-hot grant), req_a/req_b/req_cin per-requester slices;
//        rsp_valid/rsp_ready with rsp_id, rsp_sum, rsp_cout.
// Option BK_SCHED_STATS_EN adds stat_ops (completed handshakes) and stat_busy
// (cycles outside IDLE), both 32-bit wrapping counters.
module bk_add_scheduler
    import bk_sched_pkg::*;
#(
    parameter int NREQ  = 2,
    parameter int WORDS = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NREQ-1:0]               req_valid,
    output logic [NREQ-1:0]               req_ready,
    input  logic [NREQ*BK_W*WORDS-1:0]    req_a,
    input  logic [NREQ*BK_W*WORDS-1:0]    req_b,
    input  logic [NREQ-1:0]               req_cin,
    output logic                          rsp_valid,
    input  logic                          rsp_ready,
    output logic [id_width(NREQ)-1:0]     rsp_id,
    output logic [BK_W*WORDS-1:0]         rsp_sum,
    output logic                          rsp_cout
`ifdef BK_SCHED_STATS_EN
    ,
    output logic [31:0]                   stat_ops,
    output logic [31:0]                   stat_busy
`endif
);

    localparam int OPW = BK_W * WORDS;
    localparam int IDW = id_width(NREQ);
    localparam int KW  = (WORDS > 1) ? $clog2(WORDS) : 1;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [IDW-1:0]  r_last_grant;
    logic [IDW-1:0]  r_id;
    logic [OPW-1:0]  r_a;
    logic [OPW-1:0]  r_b;
    logic [OPW-1:0]  r_sum;
    logic            r_carry;
    logic            r_cout;
    logic [KW-1:0]   r_k;

    logic [NREQ-1:0] w_grant;
    logic            w_accept;
    logic            w_last_word;
    logic [IDW-1:0]  w_gnt_id;
    logic [OPW-1:0]  w_sel_a;
    logic [OPW-1:0]  w_sel_b;
    logic            w_sel_cin;
    logic [BK_W-1:0] w_add_a;
    logic [BK_W-1:0] w_add_b;
    logic [BK_W-1:0] w_add_s;
    logic            w_add_cout;

    rr_arb #(.NREQ(NREQ)) u_arb (
        .req        (req_valid),
        .last_grant (r_last_grant),
        .grant      (w_grant)
    );

    // Grant only in IDLE; rst gates it so nothing is offered while reset is held.
    assign req_ready = (r_state == IDLE && !rst) ? w_grant : '0;
    assign w_accept  = |(req_valid & req_ready);

    // Pull the granted requester's operands out of the flat input buses.
    always_comb begin
        w_gnt_id  = '0;
        w_sel_a   = '0;
        w_sel_b   = '0;
        w_sel_cin = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_grant[i]) begin
                w_gnt_id  = IDW'(i);
                w_sel_a   = req_a[i*OPW +: OPW];
                w_sel_b   = req_b[i*OPW +: OPW];
                w_sel_cin = req_cin[i];
            end
        end
    end

    // Current word of the latched operands feeds the adder.
    always_comb begin
        w_add_a = '0;
        w_add_b = '0;
        for (int w = 0; w < WORDS; w++) begin
            if (r_k == KW'(w)) begin
                w_add_a = r_a[w*BK_W +: BK_W];
                w_add_b = r_b[w*BK_W +: BK_W];
            end
        end
    end

    assign w_last_word = (r_k == KW'(WORDS - 1));

    BrentKung u_add (
        .A    (w_add_a),
        .B    (w_add_b),
        .Cin  (r_carry),
        .S    (w_add_s),
        .Cout (w_add_cout)
    );

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_accept)    w_state_nxt = RUN;
            RUN:     if (w_last_word) w_state_nxt = DONE;
            DONE:    if (rsp_ready)   w_state_nxt = IDLE;
            default:                  w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_last_grant <= IDW'(NREQ - 1);
            r_id         <= '0;
            r_a          <= '0;
            r_b          <= '0;
            r_sum        <= '0;
            r_carry      <= 1'b0;
            r_cout       <= 1'b0;
            r_k          <= '0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_a          <= w_sel_a;
                        r_b          <= w_sel_b;
                        r_carry      <= w_sel_cin;
                        r_id         <= w_gnt_id;
                        r_last_grant <= w_gnt_id;
                        r_k          <= '0;
                    end
                end
                RUN: begin
                    for (int w = 0; w < WORDS; w++) begin
                        if (r_k == KW'(w)) begin
                            r_sum[w*BK_W +: BK_W] <= w_add_s;
                        end
                    end
                    r_carry <= w_add_cout;
                    r_k     <= w_last_word ? '0 : r_k + KW'(1);
                    if (w_last_word) begin
                        r_cout <= w_add_cout;
                    end
                end
                default: ;
            endcase
        end
    end

    assign rsp_valid = (r_state == DONE);
    assign rsp_id    = r_id;
    assign rsp_sum   = r_sum;
    assign rsp_cout  = r_cout;

`ifdef BK_SCHED_STATS_EN
    logic [31:0] r_stat_ops;
    logic [31:0] r_stat_busy;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stat_ops  <= '0;
            r_stat_busy <= '0;
        end else begin
            if (rsp_valid && rsp_ready) begin
                r_stat_ops <= r_stat_ops + 32'd1;
            end
            if (r_state != IDLE) begin
                r_stat_busy <= r_stat_busy + 32'd1;
            end
        end
    end

    assign stat_ops  = r_stat_ops;
    assign stat_busy = r_stat_busy;
`endif

endmodule

// File: tb/tb_bk_add_scheduler.sv
// Bench for bk_add_scheduler: directed vectors, expectations queued at accept,
// a monitor process pops and compares on every response handshake.
module tb_bk_add_scheduler;

    localparam int NREQ  = 2;
    localparam int WORDS = 4;
    localparam int OPW   = 64;
    localparam int LAT   = WORDS + 1;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [NREQ-1:0]        req_valid;
    logic [NREQ-1:0]        req_ready;
    logic [NREQ*OPW-1:0]    req_a;
    logic [NREQ*OPW-1:0]    req_b;
    logic [NREQ-1:0]        req_cin;
    logic                   rsp_valid;
    logic                   rsp_ready;
    logic [0:0]             rsp_id;
    logic [OPW-1:0]         rsp_sum;
    logic                   rsp_cout;
`ifdef BK_SCHED_STATS_EN
    logic [31:0]            stat_ops;
    logic [31:0]            stat_busy;
`endif

    bk_add_scheduler #(.NREQ(NREQ), .WORDS(WORDS)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_cin   (req_cin),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_sum   (rsp_sum),
        .rsp_cout  (rsp_cout)
`ifdef BK_SCHED_STATS_EN
        ,
        .stat_ops  (stat_ops),
        .stat_busy (stat_busy)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          id;
        logic [63:0] sum;
        logic        cout;
    } exp_t;

    exp_t sb[$];
    int   acc_q[$];
    logic r_prev_vld = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic set_req(input int idx, input logic v, input logic [63:0] a,
                           input logic [63:0] b, input logic c);
        if (idx == 0) begin
            req_valid[0] = v; req_a[63:0] = a; req_b[63:0] = b; req_cin[0] = c;
        end else begin
            req_valid[1] = v; req_a[127:64] = a; req_b[127:64] = b; req_cin[1] = c;
        end
    endtask

    task automatic push_exp(input int id, input logic [63:0] s, input logic co, input int at);
        exp_t e;
        e.id = id; e.sum = s; e.cout = co;
        sb.push_back(e);
        acc_q.push_back(at);
    endtask

    // Call at a falling edge; returns who was accepted on the next rising edge.
    task automatic wait_acc(output int who, output int at);
        who = -1;
        at  = 0;
        for (int t = 0; t < 60; t++) begin
            #1;
            if (|(req_valid & req_ready)) begin
                who = (req_valid[1] & req_ready[1]) ? 1 : 0;
                at  = cyc;
                return;
            end
            @(negedge clk);
        end
    endtask

    task automatic do_op(input int idx, input logic [63:0] a, input logic [63:0] b,
                         input logic c, input logic [63:0] es, input logic ec, input string name);
        int who, at;
        @(negedge clk);
        set_req(idx, 1'b1, a, b, c);
        wait_acc(who, at);
        check({name, "_grant"}, who, idx);
        if (who == idx) push_exp(idx, es, ec, at);
        @(posedge clk);
        #1;
        // Scramble the operands: they must not affect the in-flight result.
        set_req(idx, 1'b0, {$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom));
    endtask

    task automatic drain(input string name);
        for (int t = 0; t < 100; t++) begin
            if (sb.size() == 0) break;
            @(negedge clk);
        end
        check({name, "_drain"}, sb.size(), 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        req_valid = '1;
        @(negedge clk);
        @(negedge clk);
        #1;
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_req_ready", req_ready, 0);
        check("rst_rsp_sum",   rsp_sum,   0);
        check("rst_rsp_cout",  rsp_cout,  0);
        check("rst_rsp_id",    rsp_id,    0);
        req_valid = '0;
        sb.delete();
        acc_q.delete();
        rst = 1'b0;
    endtask

    // Monitor: latency on each rising rsp_valid, payload on each handshake.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (rst) begin
                r_prev_vld = 1'b0;
            end else begin
                if (rsp_valid && !r_prev_vld) begin
                    if (acc_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_rsp: actual=rsp_valid required=no response");
                    end else begin
                        check("latency", cyc - acc_q.pop_front(), LAT);
                    end
                end
                if (rsp_valid && rsp_ready) begin
                    if (sb.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_hs: actual=handshake required=none");
                    end else begin
                        e = sb.pop_front();
                        check("rsp_id",   rsp_id,   e.id);
                        check("rsp_sum",  rsp_sum,  e.sum);
                        check("rsp_cout", rsp_cout, e.cout);
                    end
                end
                r_prev_vld = rsp_valid;
            end
        end
    end

    typedef struct {
        int          idx;
        logic [63:0] a;
        logic [63:0] b;
        logic        cin;
        logic [63:0] sum;
        logic        cout;
    } vec_t;

    vec_t vecs[5] = '{
        '{0, 64'h0000_0000_0000_FFFF, 64'h0000_0000_0000_0001, 1'b0, 64'h0000_0000_0001_0000, 1'b0},
        '{0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0000_0000_0000, 1'b1, 64'h0000_0000_0000_0000, 1'b1},
        '{0, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 64'h0000_0000_0000_0000, 1'b1},
        '{0, 64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b1, 64'h2222_2222_2222_2212, 1'b0},
        '{1, 64'hFFFF_0000_FFFF_0000, 64'h0001_FFFF_0001_FFFF, 1'b0, 64'h0001_0000_0000_FFFF, 1'b1}
    };

    initial begin
        int who, at, prev_at, hs, seen;
        rst       = 1'b1;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        req_cin   = '0;
        rsp_ready = 1'b1;

        do_reset();

        // Directed vectors, one requester at a time.
        foreach (vecs[i]) begin
            do_op(vecs[i].idx, vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sum, vecs[i].cout, "vec");
        end
        drain("vec");

        // Both requesters contending from reset: 0,1,0,1 with 6-cycle spacing.
        do_reset();
        @(negedge clk);
        set_req(0, 1'b1, 64'h1,  64'h2,  1'b0);
        set_req(1, 1'b1, 64'h10, 64'h20, 1'b1);
        prev_at = 0;
        for (int n = 0; n < 4; n++) begin
            wait_acc(who, at);
            check("alt_grant", who, n % 2);
            if (n > 0) check("alt_gap", at - prev_at, 6);
            if (who == 0) push_exp(0, 64'h3, 1'b0, at);
            if (who == 1) push_exp(1, 64'h31, 1'b0, at);
            prev_at = at;
            @(negedge clk);
        end
        req_valid = '0;
        drain("alt");

        // Backpressure: hold rsp_ready low for 3 DONE cycles.
        @(negedge clk);
        rsp_ready = 1'b0;
        set_req(0, 1'b1, 64'h00FF_00FF_00FF_00FF, 64'h0F01_0F01_0F01_0F01, 1'b0);
        wait_acc(who, at);
        check("hold_grant", who, 0);
        if (who == 0) push_exp(0, 64'h1000_1000_1000_1000, 1'b0, at);
        @(posedge clk);
        #1;
        set_req(0, 1'b0, 64'h0, 64'h0, 1'b0);
        set_req(1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            #1;
            if (rsp_valid) break;
        end
        check("hold_rsp_valid", rsp_valid, 1);
        for (int h = 0; h < 3; h++) begin
            check("hold_valid",     rsp_valid, 1);
            check("hold_sum",       rsp_sum,   64'h1000_1000_1000_1000);
            check("hold_cout",      rsp_cout,  0);
            check("hold_id",        rsp_id,    0);
            check("hold_req_ready", req_ready, 0);
            @(negedge clk);
            #1;
        end
        rsp_ready = 1'b1;
        check("hs_req_ready", req_ready, 0);
        hs = cyc;
        @(negedge clk);
        check("hold_valid_drop", rsp_valid, 0);
        wait_acc(who, at);
        check("hold_next_grant", who, 1);
        check("hold_next_gap", at - hs, 1);
        if (who == 1) push_exp(1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, at);
        @(posedge clk);
        #1;
        req_valid = '0;
        drain("hold");

        // Reset in flight: req1 accepted, reset two cycles later, no response.
        do_op(0, 64'h5, 64'h6, 1'b0, 64'hB, 1'b0, "pre");
        drain("pre");
        @(negedge clk);
        set_req(1, 1'b1, 64'h1111, 64'h2222, 1'b0);
        wait_acc(who, at);
        check("abort_grant", who, 1);
        @(posedge clk);
        #1;
        req_valid = '0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        for (int t = 0; t < 10; t++) begin
            @(negedge clk);
            #1;
            if (rsp_valid) seen++;
        end
        check("abort_no_rsp", seen, 0);
        set_req(0, 1'b1, 64'h7, 64'h8,  1'b0);
        set_req(1, 1'b1, 64'h9, 64'hA, 1'b0);
        wait_acc(who, at);
        check("post_rst_grant", who, 0);
        if (who == 0) push_exp(0, 64'hF, 1'b0, at);
        @(posedge clk);
        #1;
        req_valid = '0;
        drain("post_rst");

`ifdef BK_SCHED_STATS_EN
        do_reset();
        for (int i = 0; i < 10; i++) begin
            do_op(0, 64'(i), 64'(i), 1'b0, 64'(2 * i), 1'b0, "stats");
        end
        drain("stats");
        @(negedge clk);
        #1;
        check("stat_ops",  stat_ops,  10);
        check("stat_busy", stat_busy, 50);
`endif

        repeat (3) @(negedge clk);
        check("sb_empty",  sb.size(),    0);
        check("acc_empty", acc_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: actual=timeout required=completion");
        $fatal(1, "watchdog");
    end

endmodule
